// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl_if
// Description : Read-side bus of the dual-clock FIFO. It groups the read
//               request, the synchronised write pointer, the status outputs,
//               the RAM read address and the Gray read pointer.
//               master : reader / CDC wrapper (drives r_inc, sync_w_ptr)
//               slave  : fifo_rd_ctrl (drives status, pointers, address)
// Revision    : 1.0  initial release
// ============================================================================
interface fifo_rd_ctrl_if #(
  parameter int ptr_width = 4
);
  logic                 r_inc;
  logic [ptr_width-1:0] sync_w_ptr;
  logic                 r_empty;
  logic                 r_almost_empty;
  logic [ptr_width-1:0] r_level;
  logic [ptr_width-1:0] gray_r_ptr;
  logic [ptr_width-2:0] r_addr;
  logic                 r_underflow;

  modport master (
    output r_inc, sync_w_ptr,
    input  r_empty, r_almost_empty, r_level, gray_r_ptr, r_addr, r_underflow
  );

  modport slave (
    input  r_inc, sync_w_ptr,
    output r_empty, r_almost_empty, r_level, gray_r_ptr, r_addr, r_underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Read-side pointer and status controller of the dual-clock
//               FIFO, read clock domain only. Keeps the binary read pointer
//               and its Gray copy, drives the RAM read address, and derives
//               registered empty / almost-empty / level from the write
//               pointer already synchronised into this domain.
// Ports       : r_clk      - read clock, rising edge
//               r_rst_n    - asynchronous active-low reset
//               bus (slave): r_inc, sync_w_ptr in;
//                            r_empty, r_almost_empty, r_level, gray_r_ptr,
//                            r_addr, r_underflow out
// Options     : FIFO_RD_UNDERFLOW_EN - when defined, r_underflow is a sticky
//               flag set by a read request while empty; otherwise tied to 0.
// Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_ctrl #(
  parameter int ptr_width = 4,  // depth = 2**(ptr_width-1), minimum 3
  parameter int ae_thresh = 1   // almost-empty when level <= ae_thresh
) (
  input wire logic      r_clk,
  input wire logic      r_rst_n,
  fifo_rd_ctrl_if.slave bus
);

  localparam logic [ptr_width-1:0] c_ae_thresh = ptr_width'(ae_thresh);

  logic [ptr_width-1:0] bin_q;
  logic [ptr_width-1:0] gray_q;
  logic [ptr_width-1:0] level_q;
  logic                 empty_q;
  logic                 almost_empty_q;

  logic                 accepted;
  logic [ptr_width-1:0] bin_next;
  logic [ptr_width-1:0] gray_next;
  logic [ptr_width-1:0] w_bin_s;
  logic [ptr_width-1:0] level_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
  // above its position.
  always_comb begin
    w_bin_s = '0;
    for (int i = 0; i < ptr_width; i++) begin
      w_bin_s[i] = ^(bus.sync_w_ptr >> i);
    end
  end

  assign accepted   = bus.r_inc & ~empty_q;
  assign bin_next   = bin_q + {{(ptr_width-1){1'b0}}, accepted};
  assign gray_next  = bin_next ^ (bin_next >> 1);
  // Modulo subtraction handles the pointer wrap; the extra MSB of the
  // pointers keeps full (2**(ptr_width-1)) distinct from empty.
  assign level_next = w_bin_s - bin_next;

  // Status is computed from the post-pop pointer so a pop is reflected on
  // the same edge; writes only show up once synchronised, which keeps the
  // flags pessimistic.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      bin_q          <= '0;
      gray_q         <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      bin_q          <= bin_next;
      gray_q         <= gray_next;
      level_q        <= level_next;
      empty_q        <= (gray_next == bus.sync_w_ptr);
      almost_empty_q <= (level_next <= c_ae_thresh);
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      underflow_q <= 1'b0;
    end else if (bus.r_inc && empty_q) begin
      underflow_q <= 1'b1;
    end
  end

  assign bus.r_underflow = underflow_q;
`else
  assign bus.r_underflow = 1'b0;
`endif

  assign bus.r_addr         = bin_q[ptr_width-2:0];
  assign bus.gray_r_ptr     = gray_q;
  assign bus.r_level        = level_q;
  assign bus.r_empty        = empty_q;
  assign bus.r_almost_empty = almost_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Self-checking bench for fifo_rd_ctrl (ptr_width=4,
//               ae_thresh=1). A reference model tracks total words written
//               and read as plain integers; every output is derived from
//               those counts each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_rd_ctrl;

  localparam int c_ptr_width = 4;
  localparam int c_ae_thresh = 1;
  localparam int c_depth     = 8;

  logic r_clk;
  logic r_rst_n;

  fifo_rd_ctrl_if #(.ptr_width(c_ptr_width)) bus ();

  fifo_rd_ctrl #(
    .ptr_width(c_ptr_width),
    .ae_thresh(c_ae_thresh)
  ) dut (
    .r_clk  (r_clk),
    .r_rst_n(r_rst_n),
    .bus    (bus)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: total words read / written since reset.
  int m_rd;
  int m_wr;
  bit m_empty;
  bit m_uf;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, want);
    end
  endtask

  task automatic check_model();
    int lvl;
    lvl = m_wr - m_rd;
    chk("level",        32'(bus.r_level),        32'(lvl));
    chk("empty",        32'(bus.r_empty),        32'(lvl == 0));
    chk("almost_empty", 32'(bus.r_almost_empty), 32'(lvl <= c_ae_thresh));
    chk("gray_r_ptr",   32'(bus.gray_r_ptr),     32'(gray4(m_rd)));
    chk("r_addr",       32'(bus.r_addr),         32'(m_rd % c_depth));
    chk("underflow",    32'(bus.r_underflow),    32'(m_uf));
  endtask

  // Called at a negedge: applies inputs, lets one rising edge happen,
  // advances the model and checks at the following negedge.
  task automatic step(input bit inc, input int wr_total);
    bus.r_inc      = inc;
    bus.sync_w_ptr = gray4(wr_total);
    m_wr           = wr_total;
    @(posedge r_clk);
`ifdef FIFO_RD_UNDERFLOW_EN
    if (inc && m_empty) m_uf = 1'b1;
`endif
    if (inc && !m_empty) m_rd++;
    m_empty = (m_wr == m_rd);
    @(negedge r_clk);
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_level"}, 32'(bus.r_level),        32'd0);
    chk({tag, "_empty"}, 32'(bus.r_empty),        32'd1);
    chk({tag, "_ae"},    32'(bus.r_almost_empty), 32'd1);
    chk({tag, "_gray"},  32'(bus.gray_r_ptr),     32'd0);
    chk({tag, "_addr"},  32'(bus.r_addr),         32'd0);
    chk({tag, "_uf"},    32'(bus.r_underflow),    32'd0);
  endtask

  // Asynchronous reset applied mid-cycle, checked before the next edge.
  task automatic do_reset();
    #2;
    r_rst_n        = 1'b0;
    bus.r_inc      = 1'b0;
    bus.sync_w_ptr = '0;
    #1;
    check_reset_values("rst");
    m_rd = 0; m_wr = 0; m_empty = 1'b1; m_uf = 1'b0;
    @(negedge r_clk);
    r_rst_n = 1'b1;
  endtask

  initial begin
    r_rst_n        = 1'b0;
    bus.r_inc      = 1'b0;
    bus.sync_w_ptr = '0;
    m_rd = 0; m_wr = 0; m_empty = 1'b1; m_uf = 1'b0;
    @(negedge r_clk);
    @(negedge r_clk);
    check_reset_values("por");
    r_rst_n = 1'b1;

    // Fill visibility: write pointer jumps to 3 (Gray 0010).
    step(1'b0, 3);
    chk("fill_level", 32'(bus.r_level), 32'd3);
    chk("fill_empty", 32'(bus.r_empty), 32'd0);
    chk("fill_ae",    32'(bus.r_almost_empty), 32'd0);

    // Drain three words, then a rejected fourth read.
    step(1'b1, 3);
    chk("drain1_gray", 32'(bus.gray_r_ptr), 32'h1);
    chk("drain1_addr", 32'(bus.r_addr), 32'd1);
    chk("drain1_ae",   32'(bus.r_almost_empty), 32'd0);
    step(1'b1, 3);
    chk("drain2_gray", 32'(bus.gray_r_ptr), 32'h3);
    chk("drain2_ae",   32'(bus.r_almost_empty), 32'd1);
    chk("drain2_empty",32'(bus.r_empty), 32'd0);
    step(1'b1, 3);
    chk("drain3_gray", 32'(bus.gray_r_ptr), 32'h2);
    chk("drain3_addr", 32'(bus.r_addr), 32'd3);
    chk("drain3_empty",32'(bus.r_empty), 32'd1);
    step(1'b1, 3);
    chk("drain4_gray", 32'(bus.gray_r_ptr), 32'h2);
    chk("drain4_addr", 32'(bus.r_addr), 32'd3);
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("uf_set", 32'(bus.r_underflow), 32'd1);
    step(1'b0, 4);
    chk("uf_sticky", 32'(bus.r_underflow), 32'd1);
`else
    chk("uf_off", 32'(bus.r_underflow), 32'd0);
`endif

    // Full occupancy then complete drain with address wrap 7 -> 0.
    do_reset();
    step(1'b0, 8);
    chk("full_level", 32'(bus.r_level), 32'd8);
    chk("full_empty", 32'(bus.r_empty), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 8);
    chk("full_addr7", 32'(bus.r_addr), 32'd7);
    step(1'b1, 8);
    chk("full_addr0", 32'(bus.r_addr), 32'd0);
    chk("full_empty_end", 32'(bus.r_empty), 32'd1);

    // Pointer wrap 15 -> 0 with the writer ahead across the boundary.
    do_reset();
    step(1'b0, 8);
    for (int i = 0; i < 8; i++) step(1'b1, 8);
    step(1'b0, 14);
    for (int i = 0; i < 6; i++) step(1'b1, 14);
    step(1'b0, 18);
    chk("wrap_level4", 32'(bus.r_level), 32'd4);
    step(1'b1, 18);
    chk("wrap_gray15", 32'(bus.gray_r_ptr), 32'h8);
    step(1'b1, 18);
    chk("wrap_gray0", 32'(bus.gray_r_ptr), 32'h0);
    chk("wrap_level2", 32'(bus.r_level), 32'd2);

    // Random traffic with a legal writer (one step per cycle, never over depth).
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int  wr;
      bit  inc;
      if (i == 200) do_reset();
      wr  = m_wr;
      if ((m_wr - m_rd) < c_depth && ($urandom_range(0, 2) != 0)) wr = m_wr + 1;
      inc = ($urandom_range(0, 1) == 1);
      step(inc, wr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side pointer and status controller for the dual-clock FIFO, running entirely in the read clock domain. It keeps the binary read pointer and its Gray-coded copy, and drives the RAM read address. From the write pointer (already synchronised into the read domain), it computes a registered empty flag, occupancy level and almost-empty flag. It pairs with the write-side pointer block; `gray_r_ptr` crosses to the write domain through the existing two-flop synchroniser.

## Interface
Parameters:
- `ptr_width`, default 4: pointer width; FIFO depth = 2^(ptr_width-1); minimum 3.
- `ae_thresh`, default 1: almost-empty asserts when occupancy ≤ this value; range 0..2^(ptr_width-1).

Ports:
- `r_clk` in 1: read clock. Single clock; all state is on the rising edge.
- `r_rst_n` in 1: reset. Asynchronous assert, active-low.
- `r_inc` in 1: read request; pops one word when accepted.
- `sync_w_ptr` in ptr_width: Gray write pointer, already synchronised to `r_clk`.
- `r_empty` out 1: FIFO empty, registered.
- `r_almost_empty` out 1: occupancy ≤ `ae_thresh`, registered.
- `r_level` out ptr_width: occupancy as seen by the reader, 0..2^(ptr_width-1), registered.
- `gray_r_ptr` out ptr_width: Gray read pointer, registered, sent to the write domain.
- `r_addr` out ptr_width-1: RAM read address.
- `r_underflow` out 1: sticky underflow error (see Configuration).

## Operation
- Read acceptance: a read is accepted when `r_inc && !r_empty`. A read requested while empty is ignored; pointers are unchanged.
- Next binary pointer: `r_bin_next = r_bin + accepted`, modulo 2^ptr_width. Wrap from all-ones to 0 is natural.
- Next Gray pointer: `r_gray_next = r_bin_next ^ (r_bin_next >> 1)`. Both `r_bin` and `gray_r_ptr` load the "next" values on the same edge, so the Gray pointer never lags the binary pointer. Only one Gray bit changes per accepted read.
- Address: `r_addr = r_bin[ptr_width-2:0]`, combinational from the register.
- Write-pointer decode: `w_bin_s` is the Gray-to-binary conversion of `sync_w_ptr`, a combinational XOR prefix from the MSB down.
- Occupancy: `r_level <= w_bin_s - r_bin_next`, ptr_width-bit modulo subtraction. The result never exceeds 2^(ptr_width-1) for a legal writer.
- Empty: `r_empty <= (r_gray_next == sync_w_ptr)`. This is equivalent to next level == 0; `r_empty` is 1 exactly when `r_level` is 0.
- Almost empty: `r_almost_empty <= (w_bin_s - r_bin_next) <= ae_thresh`.
- Empty and almost-empty are pessimistic: they assert immediately on the reader's own pop and release only after a write is visible through the synchroniser.

## Timing
- Reset values (asynchronous):
  - `r_bin` = 0, `gray_r_ptr` = 0, `r_addr` = 0
  - `r_empty` = 1, `r_almost_empty` = 1, `r_level` = 0, `r_underflow` = 0
- Read latency:
  - The edge that accepts a read advances `r_addr` and `gray_r_ptr`.
  - The data word for the old address is valid during the accepting cycle.
  - Status flags reflect the pop on the same edge.
- Write visibility: a change on `sync_w_ptr` reaches `r_level`, `r_empty` and `r_almost_empty` 1 cycle later.
- Simultaneous pop and write arrival: both are included in the same registered update; the net level is unchanged.
- Last word: the pop that takes the last word sets `r_empty` = 1 on that edge. `r_inc` held high in the following cycle is ignored.
- Reset mid-operation: all state returns to reset values immediately. The write side must be reset together with the read side.

## Configuration
- Macro `FIFO_RD_UNDERFLOW_EN` defined:
  - `r_underflow` sets when `r_inc && r_empty` at a clock edge.
  - It stays set until `r_rst_n` is asserted.
- Macro undefined:
  - `r_underflow` is tied to 0 and no flop is built.
  - Rejected reads are still ignored.

## Test plan
All scenarios use ptr_width=4, ae_thresh=1.
- Reset: assert `r_rst_n`=0 mid-stream -> outputs immediately equal the reset values, with `r_empty`=1 and `r_level`=0.
- Fill visibility: `sync_w_ptr` changes from 0000 to 0010 (binary 3) -> 1 cycle later `r_level`=3, `r_empty`=0, `r_almost_empty`=0.
- Drain: hold `r_inc` for 3 cycles from level 3.
  - `r_addr` steps 0, 1, 2, 3.
  - `gray_r_ptr` steps 0000, 0001, 0011, 0010.
  - `r_almost_empty`=1 after the 2nd pop; `r_empty`=1 after the 3rd pop.
  - A 4th `r_inc` -> no change to the pointers.
- Full occupancy: `sync_w_ptr`=1100 (binary 8) with `r_bin`=0 -> `r_level`=8 and `r_empty`=0. Pop 8 words -> `r_empty`=1 and `r_addr` wraps 7→0.
- Pointer wrap: drive the read pointer from 15 to 0 with a writer ahead.
  - `gray_r_ptr` goes 1000→0000.
  - `r_level` stays correct across the modulo boundary, e.g. `w_bin_s`=2, `r_bin`=14 -> level 4.
- Underflow: with the macro defined, `r_inc`=1 while empty -> `r_underflow`=1 and it persists until reset. Without the macro, `r_underflow` stays 0.
